// File: rtl/fp51_pwm_multi_if.sv
// FP51 SFR bus bundle: 8-bit read and write channels towards one peripheral.
// Each request is strobed for one cycle; the peripheral answers with a
// one-cycle ACK on the following cycle, with read data valid alongside it.
interface fp51_pwm_multi_if;
    logic       WB_RD_STB_I;
    logic [7:0] WB_RD_ADR_I;
    logic [7:0] WB_RD_DAT_O;
    logic       WB_RD_ACK_O;
    logic       WB_WR_STB_I;
    logic       WB_WR_WE_I;
    logic [7:0] WB_WR_ADR_I;
    logic [7:0] WB_WR_DAT_I;
    logic       WB_WR_ACK_O;

    modport master (
        output WB_RD_STB_I, WB_RD_ADR_I, WB_WR_STB_I, WB_WR_WE_I, WB_WR_ADR_I, WB_WR_DAT_I,
        input  WB_RD_DAT_O, WB_RD_ACK_O, WB_WR_ACK_O
    );

    modport slave (
        input  WB_RD_STB_I, WB_RD_ADR_I, WB_WR_STB_I, WB_WR_WE_I, WB_WR_ADR_I, WB_WR_DAT_I,
        output WB_RD_DAT_O, WB_RD_ACK_O, WB_WR_ACK_O
    );
endinterface

// File: rtl/fp51_pwm_multi.sv
// Multi-channel PWM: one shared prescaled counter (edge or center aligned),
// per-channel compare, double-buffered period/duty committed at the period
// boundary, and a sticky period-end interrupt flag.
module fp51_pwm_multi #(
    parameter int         NUM_OF_PWM = 4,
    parameter int         CNT_WIDTH  = 16,
    parameter logic [7:0] BASE_ADDR  = 8'hE0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    fp51_pwm_multi_if.slave       bus,
    output logic [NUM_OF_PWM-1:0] pwm_out,
    output logic                  int_req
);
    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

    logic                 enable, center, irq_en, irq_flag;
    logic [7:0]           prescale, period_lo, duty_lo;
    logic [2:0]           ch_sel;
    logic [CNT_WIDTH-1:0] period_shadow, period_active;
    logic [CNT_WIDTH-1:0] duty_shadow [NUM_OF_PWM];
    logic [CNT_WIDTH-1:0] duty_active [NUM_OF_PWM];
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic [7:0]           presc_cnt;
    dir_t                 dir, dir_nxt;
    logic                 tick, boundary;
    logic [NUM_OF_PWM-1:0] pwm_q;
    logic                 rd_ack, wr_ack;
    logic [7:0]           rd_dat, rd_mux;
    logic [7:0]           wr_off, rd_off;
    logic                 wr_hit, rd_hit;
    logic [15:0]          period_word, duty_word, period_rd, duty_rd;
    logic [CNT_WIDTH-1:0] duty_sel;

    // Window decode: offsets 0..6 from BASE_ADDR belong to this block.
    assign wr_off      = bus.WB_WR_ADR_I - BASE_ADDR;
    assign rd_off      = bus.WB_RD_ADR_I - BASE_ADDR;
    assign wr_hit      = bus.WB_WR_STB_I & bus.WB_WR_WE_I & (wr_off <= 8'd6);
    assign rd_hit      = bus.WB_RD_STB_I & (rd_off <= 8'd6);
    assign period_word = {bus.WB_WR_DAT_I, period_lo};
    assign duty_word   = {bus.WB_WR_DAT_I, duty_lo};

    // Register file: high-byte writes commit the {H,L} pair into a shadow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable        <= 1'b0;
            center        <= 1'b0;
            irq_en        <= 1'b0;
            irq_flag      <= 1'b0;
            prescale      <= '0;
            period_lo     <= '0;
            duty_lo       <= '0;
            ch_sel        <= '0;
            period_shadow <= '0;
            for (int i = 0; i < NUM_OF_PWM; i++) duty_shadow[i] <= '0;
        end else begin
            if (wr_hit) begin
                case (wr_off[2:0])
                    3'd0: begin
                        enable <= bus.WB_WR_DAT_I[0];
                        center <= bus.WB_WR_DAT_I[1];
                        irq_en <= bus.WB_WR_DAT_I[2];
                    end
                    3'd1: prescale      <= bus.WB_WR_DAT_I;
                    3'd2: period_lo     <= bus.WB_WR_DAT_I;
                    3'd3: period_shadow <= period_word[CNT_WIDTH-1:0];
                    3'd4: ch_sel        <= bus.WB_WR_DAT_I[2:0];
                    3'd5: duty_lo       <= bus.WB_WR_DAT_I;
                    3'd6: begin
                        // Channels that do not exist simply never match.
                        for (int i = 0; i < NUM_OF_PWM; i++)
                            if (ch_sel == 3'(i)) duty_shadow[i] <= duty_word[CNT_WIDTH-1:0];
                    end
                    default: ;
                endcase
            end
            // A boundary in the same cycle as a W1C keeps the flag set.
            if (boundary)
                irq_flag <= 1'b1;
            else if (wr_hit && wr_off[2:0] == 3'd0 && bus.WB_WR_DAT_I[7])
                irq_flag <= 1'b0;
        end
    end

    // Next counter state: prescaler tick, edge/center stepping, boundary detect.
    always_comb begin
        tick     = enable && (presc_cnt >= prescale);
        cnt_nxt  = cnt;
        dir_nxt  = dir;
        boundary = 1'b0;
        if (!enable) begin
            cnt_nxt = '0;
            dir_nxt = DIR_UP;
        end else begin
            if (!center) dir_nxt = DIR_UP;
            if (tick) begin
                if (!center) begin
                    if (cnt >= period_active) begin
                        cnt_nxt  = '0;
                        boundary = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end else if (period_active == '0) begin
                    cnt_nxt  = '0;
                    dir_nxt  = DIR_UP;
                    boundary = 1'b1;
                end else if (dir == DIR_UP) begin
                    if (cnt >= period_active) begin
                        dir_nxt = DIR_DOWN;
                        cnt_nxt = cnt - 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end else if (cnt == '0) begin
                    // Bottom of the triangle: restart upward from 1 so the
                    // zero count is not repeated, unless the new period is 0.
                    boundary = 1'b1;
                    dir_nxt  = DIR_UP;
                    cnt_nxt  = (period_shadow == '0) ? '0 : {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
        end
    end

    // Counter, prescaler and direction registers; active copies follow the
    // shadows while disabled and reload only at a boundary while running.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt           <= '0;
            presc_cnt     <= '0;
            dir           <= DIR_UP;
            period_active <= '0;
            pwm_q         <= '0;
            for (int i = 0; i < NUM_OF_PWM; i++) duty_active[i] <= '0;
        end else begin
            cnt       <= cnt_nxt;
            dir       <= dir_nxt;
            presc_cnt <= (!enable || tick) ? 8'd0 : presc_cnt + 8'd1;
            if (!enable || boundary) begin
                period_active <= period_shadow;
                for (int i = 0; i < NUM_OF_PWM; i++) duty_active[i] <= duty_shadow[i];
            end
            for (int i = 0; i < NUM_OF_PWM; i++)
                pwm_q[i] <= enable && (cnt < duty_active[i]);
        end
    end

    // Read data mux; absent channels and bits above CNT_WIDTH read as zero.
    always_comb begin
        duty_sel = '0;
        for (int i = 0; i < NUM_OF_PWM; i++)
            if (ch_sel == 3'(i)) duty_sel = duty_shadow[i];
        period_rd = 16'(period_shadow);
        duty_rd   = 16'(duty_sel);
        case (rd_off[2:0])
            3'd0:    rd_mux = {irq_flag, 4'b0000, irq_en, center, enable};
            3'd1:    rd_mux = prescale;
            3'd2:    rd_mux = period_rd[7:0];
            3'd3:    rd_mux = period_rd[15:8];
            3'd4:    rd_mux = {5'b00000, ch_sel};
            3'd5:    rd_mux = duty_rd[7:0];
            3'd6:    rd_mux = duty_rd[15:8];
            default: rd_mux = 8'h00;
        endcase
    end

    // Bus responses: one-cycle ACKs, read data registered with its ACK.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ack <= 1'b0;
            wr_ack <= 1'b0;
            rd_dat <= 8'h00;
        end else begin
            rd_ack <= rd_hit;
            wr_ack <= wr_hit;
            rd_dat <= rd_hit ? rd_mux : 8'h00;
        end
    end

    assign bus.WB_RD_ACK_O = rd_ack;
    assign bus.WB_WR_ACK_O = wr_ack;
    assign bus.WB_RD_DAT_O = rd_dat;
    assign pwm_out         = pwm_q;
    assign int_req         = irq_flag & irq_en;
endmodule

// File: tb/tb_fp51_pwm_multi.sv
// Directed bench for fp51_pwm_multi: register access, edge/center waveforms,
// buffered duty update, prescaler, interrupt flag and asynchronous reset.
module tb_fp51_pwm_multi;
    localparam logic [7:0] BASE = 8'hE0;

    logic       clk;
    logic       reset_n;
    logic [3:0] pwm_out;
    logic       int_req;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic       last_wr_ack;

    fp51_pwm_multi_if bus ();

    fp51_pwm_multi #(.NUM_OF_PWM(4), .CNT_WIDTH(16), .BASE_ADDR(8'hE0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .pwm_out (pwm_out),
        .int_req (int_req)
    );

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Driver tasks: drive on a falling edge, the DUT samples on the next rising
    // edge, and the ACK/data are sampled on the falling edge after that.
    task automatic wb_write(input logic [7:0] off, input logic [7:0] data);
        @(negedge clk);
        bus.WB_WR_STB_I = 1'b1;
        bus.WB_WR_WE_I  = 1'b1;
        bus.WB_WR_ADR_I = BASE + off;
        bus.WB_WR_DAT_I = data;
        @(negedge clk);
        last_wr_ack     = bus.WB_WR_ACK_O;
        bus.WB_WR_STB_I = 1'b0;
        bus.WB_WR_WE_I  = 1'b0;
    endtask

    task automatic wb_read(input logic [7:0] off, output logic [7:0] data, output logic ack);
        @(negedge clk);
        bus.WB_RD_STB_I = 1'b1;
        bus.WB_RD_ADR_I = BASE + off;
        @(negedge clk);
        data            = bus.WB_RD_DAT_O;
        ack             = bus.WB_RD_ACK_O;
        bus.WB_RD_STB_I = 1'b0;
    endtask

    task automatic set_duty(input logic [2:0] ch, input logic [15:0] val);
        wb_write(8'd4, {5'b0, ch});
        wb_write(8'd5, val[7:0]);
        wb_write(8'd6, val[15:8]);
    endtask

    task automatic wait_pwm0_rise(output bit ok);
        logic prev;
        ok   = 1'b0;
        prev = pwm_out[0];
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (pwm_out[0] && !prev) begin
                ok = 1'b1;
                break;
            end
            prev = pwm_out[0];
        end
    endtask

    task automatic wait_irq(output bit ok, output int when);
        ok   = 1'b0;
        when = 0;
        for (int k = 0; k < 30; k++) begin
            if (int_req) begin
                ok   = 1'b1;
                when = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        logic [7:0] d;
        logic       a;
        total++;
        if (pwm_out !== 4'b0000) begin bad++; $display("FAIL reset_pwm: got %b want 0000", pwm_out); end
        total++;
        if (int_req !== 1'b0) begin bad++; $display("FAIL reset_int: got %b want 0", int_req); end
        for (int r = 0; r < 7; r++) begin
            wb_read(8'(r), d, a);
            total++;
            if (a !== 1'b1) begin bad++; $display("FAIL reset_ack reg%0d: got %b want 1", r, a); end
            total++;
            if (d !== 8'h00) begin bad++; $display("FAIL reset_data reg%0d: got %02h want 00", r, d); end
        end
        wb_read(8'd7, d, a);
        total++;
        if (a !== 1'b0) begin bad++; $display("FAIL oow_rd_ack: got %b want 0", a); end
        total++;
        if (d !== 8'h00) begin bad++; $display("FAIL oow_rd_data: got %02h want 00", d); end
        wb_write(8'd7, 8'hFF);
        total++;
        if (last_wr_ack !== 1'b0) begin bad++; $display("FAIL oow_wr_ack: got %b want 0", last_wr_ack); end
        wb_write(8'd1, 8'h00);
        total++;
        if (last_wr_ack !== 1'b1) begin bad++; $display("FAIL wr_ack: got %b want 1", last_wr_ack); end
    endtask

    task automatic test_readback;
        logic [7:0] d;
        logic       a;
        wb_write(8'd4, 8'hFD);
        wb_read(8'd4, d, a);
        total++;
        if (d !== 8'h05) begin bad++; $display("FAIL ch_sel_rb: got %02h want 05", d); end
        wb_write(8'd5, 8'h34);
        wb_write(8'd6, 8'h12);
        wb_read(8'd5, d, a);
        total++;
        if (d !== 8'h00) begin bad++; $display("FAIL oor_duty_l: got %02h want 00", d); end
        wb_read(8'd6, d, a);
        total++;
        if (d !== 8'h00) begin bad++; $display("FAIL oor_duty_h: got %02h want 00", d); end
        set_duty(3'd3, 16'hABCD);
        wb_read(8'd5, d, a);
        total++;
        if (d !== 8'hCD) begin bad++; $display("FAIL duty3_l: got %02h want cd", d); end
        wb_read(8'd6, d, a);
        total++;
        if (d !== 8'hAB) begin bad++; $display("FAIL duty3_h: got %02h want ab", d); end
        wb_write(8'd4, 8'd2);
        wb_read(8'd5, d, a);
        total++;
        if (d !== 8'h00) begin bad++; $display("FAIL duty2_untouched: got %02h want 00", d); end
        wb_write(8'd2, 8'h78);
        wb_read(8'd2, d, a);
        total++;
        if (d !== 8'h00) begin bad++; $display("FAIL period_l_before_h: got %02h want 00", d); end
        wb_write(8'd3, 8'h56);
        wb_read(8'd2, d, a);
        total++;
        if (d !== 8'h78) begin bad++; $display("FAIL period_l: got %02h want 78", d); end
        wb_read(8'd3, d, a);
        total++;
        if (d !== 8'h56) begin bad++; $display("FAIL period_h: got %02h want 56", d); end
        wb_write(8'd0, 8'h06);
        wb_read(8'd0, d, a);
        total++;
        if (d !== 8'h06) begin bad++; $display("FAIL ctrl_rb: got %02h want 06", d); end
    endtask

    task automatic test_edge;
        logic [7:0] d;
        logic       a;
        bit         ok;
        int         t1, t2;
        logic       e0;
        wb_write(8'd1, 8'd0);
        wb_write(8'd2, 8'd9);
        wb_write(8'd3, 8'd0);
        set_duty(3'd0, 16'd3);
        set_duty(3'd1, 16'd0);
        set_duty(3'd3, 16'd0);
        set_duty(3'd2, 16'd10);
        wb_read(8'd5, d, a);
        total++;
        if (d !== 8'd10) begin bad++; $display("FAIL edge_duty2_rb: got %0d want 10", d); end
        wb_write(8'd0, 8'h05);
        wait_pwm0_rise(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL edge_start: got no rise want rise on pwm0"); end
        // Period 10: pwm0 high for counts 0..2, ch1 never, ch2 always.
        for (int j = 0; j < 20; j++) begin
            if (j > 0) @(negedge clk);
            e0 = ((j % 10) < 3);
            total++;
            if (pwm_out[0] !== e0) begin bad++; $display("FAIL edge_ch0 t%0d: got %b want %b", j, pwm_out[0], e0); end
            total++;
            if (pwm_out[1] !== 1'b0) begin bad++; $display("FAIL edge_ch1 t%0d: got %b want 0", j, pwm_out[1]); end
            total++;
            if (pwm_out[2] !== 1'b1) begin bad++; $display("FAIL edge_ch2 t%0d: got %b want 1", j, pwm_out[2]); end
        end
        wb_write(8'd0, 8'h85);
        wait_irq(ok, t1);
        wb_write(8'd0, 8'h85);
        wait_irq(ok, t2);
        total++;
        if (!ok || (t2 - t1) != 10) begin bad++; $display("FAIL edge_irq_period: got %0d want 10", t2 - t1); end
    endtask

    task automatic test_duty_update;
        bit   ok;
        logic e;
        wb_write(8'd4, 8'd0);
        wb_write(8'd5, 8'd7);
        wait_pwm0_rise(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL upd_sync: got no rise want rise on pwm0"); end
        wb_write(8'd6, 8'd0);
        // Remaining counts 3..9 of the old period stay low; then 7 high, 3 low.
        for (int k = 3; k < 20; k++) begin
            @(negedge clk);
            e = (k >= 10 && k <= 16);
            total++;
            if (pwm_out[0] !== e) begin bad++; $display("FAIL upd_ch0 t%0d: got %b want %b", k, pwm_out[0], e); end
        end
    endtask

    task automatic test_center;
        logic exp_pwm [16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                               1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic ei;
        wb_write(8'd0, 8'h00);
        wb_write(8'd2, 8'd4);
        wb_write(8'd3, 8'd0);
        set_duty(3'd0, 16'd2);
        wb_write(8'd0, 8'h87);
        total++;
        if (int_req !== 1'b0) begin bad++; $display("FAIL ctr_irq_clear: got %b want 0", int_req); end
        // Counts 0,1,2,3,4,3,2,1,0,1,...: high while count < 2, boundary at down-zero.
        for (int k = 2; k < 18; k++) begin
            @(negedge clk);
            ei = (k >= 10);
            total++;
            if (pwm_out[0] !== exp_pwm[k-2]) begin bad++; $display("FAIL ctr_ch0 t%0d: got %b want %b", k, pwm_out[0], exp_pwm[k-2]); end
            total++;
            if (int_req !== ei) begin bad++; $display("FAIL ctr_irq t%0d: got %b want %b", k, int_req, ei); end
        end
    endtask

    task automatic test_prescale_irq;
        logic ep, ei;
        wb_write(8'd0, 8'h80);
        wb_write(8'd1, 8'd2);
        wb_write(8'd2, 8'd1);
        wb_write(8'd3, 8'd0);
        set_duty(3'd0, 16'd1);
        wb_write(8'd0, 8'h85);
        total++;
        if (int_req !== 1'b0) begin bad++; $display("FAIL pre_irq_init: got %b want 0", int_req); end
        // Tick every 3 clocks: 3 high, 3 low; boundary when count 1 wraps.
        for (int k = 2; k < 9; k++) begin
            @(negedge clk);
            ep = (k <= 4 || k >= 8);
            ei = (k >= 7);
            total++;
            if (pwm_out[0] !== ep) begin bad++; $display("FAIL pre_ch0 t%0d: got %b want %b", k, pwm_out[0], ep); end
            total++;
            if (int_req !== ei) begin bad++; $display("FAIL pre_irq t%0d: got %b want %b", k, int_req, ei); end
        end
        wb_write(8'd0, 8'h85);
        total++;
        if (int_req !== 1'b0) begin bad++; $display("FAIL w1c_clear: got %b want 0", int_req); end
        total++;
        if (pwm_out[0] !== 1'b1) begin bad++; $display("FAIL pre_ch0 t10: got %b want 1", pwm_out[0]); end
        @(negedge clk);
        total++;
        if (int_req !== 1'b0) begin bad++; $display("FAIL w1c_hold: got %b want 0", int_req); end
        wb_write(8'd0, 8'h85);
        total++;
        if (int_req !== 1'b1) begin bad++; $display("FAIL w1c_set_wins: got %b want 1", int_req); end
        total++;
        if (pwm_out[0] !== 1'b0) begin bad++; $display("FAIL pre_ch0 t13: got %b want 0", pwm_out[0]); end
        @(negedge clk);
        total++;
        if (pwm_out[0] !== 1'b1) begin bad++; $display("FAIL pre_ch0 t14: got %b want 1", pwm_out[0]); end
    endtask

    task automatic test_async_reset;
        logic [7:0] d;
        logic       a;
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (pwm_out !== 4'b0000) begin bad++; $display("FAIL async_pwm: got %b want 0000", pwm_out); end
        total++;
        if (int_req !== 1'b0) begin bad++; $display("FAIL async_int: got %b want 0", int_req); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int r = 0; r < 7; r++) begin
            wb_read(8'(r), d, a);
            total++;
            if (d !== 8'h00 || a !== 1'b1) begin bad++; $display("FAIL post_reset reg%0d: got %02h ack %b want 00 ack 1", r, d, a); end
        end
    endtask

    initial begin
        bus.WB_RD_STB_I = 1'b0;
        bus.WB_RD_ADR_I = 8'h00;
        bus.WB_WR_STB_I = 1'b0;
        bus.WB_WR_WE_I  = 1'b0;
        bus.WB_WR_ADR_I = 8'h00;
        bus.WB_WR_DAT_I = 8'h00;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        test_reset();
        test_readback();
        test_edge();
        test_duty_update();
        test_center();
        test_prescale_irq();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
